// File: rtl/dualmem_ctrl_pkg.sv
// dualmem_ctrl shared types: geometry constants, FSM states, read-return tag.
// Build option DUALMEM_CTRL_RR_EN selects round-robin arbitration.
package dualmem_ctrl_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 64;
    localparam int LEN_W  = 4;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    typedef struct packed {
        logic valid;
        logic id;
        logic last;
    } rsp_t;

endpackage

// File: rtl/dualmem_ctrl_if.sv
// Requester-side and RAM-side signal bundle of dualmem_ctrl.
// The slave modport is the controller view; master is the requester/RAM view.
interface dualmem_ctrl_if;
    import dualmem_ctrl_pkg::*;

    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0]             req_we;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][LEN_W-1:0]  req_len;
    logic [1:0][BE_W-1:0]   req_be;
    logic [1:0]             wvalid;
    logic [1:0]             wready;
    logic [1:0][DATA_W-1:0] wdata;
    logic [1:0]             rvalid;
    logic [1:0]             rlast;
    logic [DATA_W-1:0]      rdata;
    logic                   mem_en;
    logic [BE_W-1:0]        mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W-1:0]      mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_len, req_be,
        input  wvalid, wdata, mem_rdata,
        output req_ready, wready, rvalid, rlast, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_len, req_be,
        output wvalid, wdata, mem_rdata,
        input  req_ready, wready, rvalid, rlast, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dualmem_ctrl_arb.sv
// Two-way burst arbiter producing a one-hot grant.
// DUALMEM_CTRL_RR_EN: round-robin against last owner lp; else requester 0 wins.
module dualmem_ctrl_arb
    import dualmem_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       lp,
    output logic [1:0] grant
);

`ifdef DUALMEM_CTRL_RR_EN
    always_comb begin
        grant = req;
        if (&req) begin
            grant = lp ? 2'b01 : 2'b10;
        end
    end
`else
    logic unused_lp;
    assign unused_lp = lp;

    always_comb begin
        grant = 2'b00;
        if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/dualmem_ctrl.sv
// Two-requester burst controller in front of the wide RAM port.
// Arbitration policy is chosen by DUALMEM_CTRL_RR_EN (see dualmem_ctrl_arb).
module dualmem_ctrl
    import dualmem_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    dualmem_ctrl_if.slave bus
);

    state_e            state_q, state_d;
    logic              lp_q, lp_d;
    logic              live_q, live_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    rsp_t              rsp_q, rsp_d;

    logic [1:0]        grant;
    logic              gid;
    logic              fire;
    logic              last_beat;
    logic [1:0]        req_ready;
    logic [1:0]        wready;
    logic              mem_en;
    logic [BE_W-1:0]   mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        rsp_oh;

    dualmem_ctrl_arb u_arb (
        .req   (bus.req_valid),
        .lp    (lp_q),
        .grant (grant)
    );

    assign gid       = grant[1];
    assign last_beat = (cnt_q == len_q);

    always_comb begin
        state_d   = state_q;
        lp_d      = lp_q;
        live_d    = 1'b1;
        id_d      = id_q;
        we_d      = we_q;
        addr_d    = addr_q;
        len_d     = len_q;
        be_d      = be_q;
        cnt_d     = cnt_q;
        rsp_d     = '0;
        req_ready = 2'b00;
        wready    = 2'b00;
        fire      = 1'b0;
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;

        unique case (state_q)
            IDLE: begin
                // live_q holds off grants during the first cycle out of reset
                req_ready = live_q ? grant : 2'b00;
                if (|req_ready) begin
                    id_d    = gid;
                    we_d    = bus.req_we[gid];
                    addr_d  = bus.req_addr[gid];
                    len_d   = bus.req_len[gid];
                    be_d    = bus.req_be[gid];
                    cnt_d   = '0;
                    lp_d    = gid;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (we_q) begin
                    wready[id_q] = 1'b1;
                    fire         = bus.wvalid[id_q];
                end else begin
                    fire = 1'b1;
                end
                if (fire) begin
                    mem_en      = 1'b1;
                    mem_we      = we_q ? be_q : '0;
                    mem_addr    = addr_q;
                    mem_wdata   = we_q ? bus.wdata[id_q] : '0;
                    addr_d      = addr_q + ADDR_W'(1);
                    cnt_d       = cnt_q + LEN_W'(1);
                    rsp_d.valid = ~we_q;
                    rsp_d.id    = id_q;
                    rsp_d.last  = last_beat;
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            lp_q    <= 1'b1;
            live_q  <= 1'b0;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            lp_q    <= lp_d;
            live_q  <= live_d;
            id_q    <= id_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
        end
    end

    assign rsp_oh = rsp_q.id ? 2'b10 : 2'b01;

    assign bus.req_ready = req_ready;
    assign bus.wready    = wready;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.rvalid    = rsp_q.valid ? rsp_oh : 2'b00;
    assign bus.rlast     = (rsp_q.valid && rsp_q.last) ? rsp_oh : 2'b00;
    assign bus.rdata     = rsp_q.valid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dualmem_ctrl.sv
// Directed bench for dualmem_ctrl with a byte-writable synchronous RAM model.
// Expected grant order follows DUALMEM_CTRL_RR_EN when it is defined.
module tb_dualmem_ctrl;
    import dualmem_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   failures = 0;

    logic [DATA_W-1:0] ram_w [0:2047] = '{default: '0};
    logic [DATA_W-1:0] wmask [0:2047] = '{default: '0};

    dualmem_ctrl_if bus ();

    dualmem_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input logic [10:0] a);
        return {16'hBEEF, 5'd0, a, 16'hF00D, 5'd0, a};
    endfunction

    // Unwritten words read back the address-derived pattern
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we == '0) begin
                bus.mem_rdata <= (ram_w[bus.mem_addr] & wmask[bus.mem_addr])
                               | (pat(bus.mem_addr) & ~wmask[bus.mem_addr]);
            end
            for (int b = 0; b < BE_W; b++) begin
                if (bus.mem_we[b]) begin
                    ram_w[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                    wmask[bus.mem_addr][8*b +: 8] <= 8'hFF;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'h0);
        chk({tag, "_wready"}, 64'(bus.wready), 64'h0);
        chk({tag, "_rvalid"}, 64'(bus.rvalid), 64'h0);
        chk({tag, "_rlast"}, 64'(bus.rlast), 64'h0);
        chk({tag, "_rdata"}, bus.rdata, 64'h0);
        chk({tag, "_mem_en"}, 64'(bus.mem_en), 64'h0);
        chk({tag, "_mem_we"}, 64'(bus.mem_we), 64'h0);
        chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'h0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 64'h0);
    endtask

    logic [1:0]        exp_g [4];
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] ga;
    logic [63:0]       w0, w1, e0, e1;

    initial begin
        rstn          = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_we    = 2'b00;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.req_be    = '0;
        bus.wvalid    = 2'b00;
        bus.wdata     = '0;
`ifdef DUALMEM_CTRL_RR_EN
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

        // Contention: both requesters valid from reset, single-beat reads
        bus.req_valid   = 2'b11;
        bus.req_addr[0] = 11'h100;
        bus.req_addr[1] = 11'h200;
        repeat (2) @(negedge clk);
        #1;
        chk_rst_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("ready_first_cycle", 64'(bus.req_ready), 64'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("cont_grant", 64'(bus.req_ready), 64'(exp_g[k]));
            chk("cont_idle_en", 64'(bus.mem_en), 64'h0);
            if (k > 0) begin
                ga = (exp_g[k-1] == 2'b01) ? 11'h100 : 11'h200;
                chk("cont_rvalid", 64'(bus.rvalid), 64'(exp_g[k-1]));
                chk("cont_rdata", bus.rdata, pat(ga));
            end
            @(negedge clk);
            #1;
            ga = (exp_g[k] == 2'b01) ? 11'h100 : 11'h200;
            chk("cont_en", 64'(bus.mem_en), 64'h1);
            chk("cont_addr", 64'(bus.mem_addr), 64'(ga));
        end
        bus.req_valid = 2'b00;
        @(negedge clk);
        #1;
        chk("cont_last_rvalid", 64'(bus.rvalid), 64'(exp_g[3]));
        chk("cont_last_rlast", 64'(bus.rlast), 64'(exp_g[3]));
        chk("cont_drain_ready", 64'(bus.req_ready), 64'h0);

        // Single 4-beat read by requester 0
        @(negedge clk);
        bus.req_valid   = 2'b01;
        bus.req_we[0]   = 1'b0;
        bus.req_addr[0] = 11'h010;
        bus.req_len[0]  = 4'd3;
        bus.req_be[0]   = 8'hFF;
        #1;
        chk("rd_ready", 64'(bus.req_ready), 64'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.req_valid = 2'b00;
            #1;
            a = 11'h010 + 11'(i);
            if (i < 4) begin
                chk("rd_en", 64'(bus.mem_en), 64'h1);
                chk("rd_we", 64'(bus.mem_we), 64'h0);
                chk("rd_addr", 64'(bus.mem_addr), 64'(a));
            end else begin
                chk("rd_done_en", 64'(bus.mem_en), 64'h0);
            end
            if (i > 0) begin
                chk("rd_rvalid", 64'(bus.rvalid), 64'h1);
                chk("rd_rdata", bus.rdata, pat(a - 11'd1));
                chk("rd_rlast", 64'(bus.rlast), (i == 4) ? 64'h1 : 64'h0);
            end else begin
                chk("rd_rvalid_lat", 64'(bus.rvalid), 64'h0);
            end
        end
        @(negedge clk);
        #1;
        chk("rd_rvalid_end", 64'(bus.rvalid), 64'h0);

        // Address wrap by requester 1
        bus.req_valid   = 2'b10;
        bus.req_we[1]   = 1'b0;
        bus.req_addr[1] = 11'h7FE;
        bus.req_len[1]  = 4'd3;
        #1;
        chk("wrap_ready", 64'(bus.req_ready), 64'h2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.req_valid = 2'b00;
            #1;
            a = 11'h7FE + 11'(i);
            if (i < 4) begin
                chk("wrap_addr", 64'(bus.mem_addr), 64'(a));
            end
            if (i > 0) begin
                chk("wrap_rvalid", 64'(bus.rvalid), 64'h2);
                chk("wrap_rdata", bus.rdata, pat(a - 11'd1));
            end
        end

        // Gapped write by requester 0, non-owner wvalid asserted
        @(negedge clk);
        w0 = 64'h1111_2222_3333_4444;
        w1 = 64'h5555_6666_7777_8888;
        bus.req_valid   = 2'b01;
        bus.req_we[0]   = 1'b1;
        bus.req_addr[0] = 11'h020;
        bus.req_len[0]  = 4'd1;
        bus.req_be[0]   = 8'h0F;
        #1;
        chk("wr_ready", 64'(bus.req_ready), 64'h1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        bus.wvalid    = 2'b11;
        bus.wdata[0]  = w0;
        bus.wdata[1]  = 64'hDEAD_DEAD_DEAD_DEAD;
        #1;
        chk("wr_wready0", 64'(bus.wready), 64'h1);
        chk("wr_en0", 64'(bus.mem_en), 64'h1);
        chk("wr_we0", 64'(bus.mem_we), 64'h0F);
        chk("wr_addr0", 64'(bus.mem_addr), 64'h020);
        chk("wr_data0", bus.mem_wdata, w0);
        repeat (2) begin
            @(negedge clk);
            bus.wvalid = 2'b10;
            #1;
            chk("wr_gap_en", 64'(bus.mem_en), 64'h0);
            chk("wr_gap_wready", 64'(bus.wready), 64'h1);
        end
        @(negedge clk);
        bus.wvalid   = 2'b01;
        bus.wdata[0] = w1;
        #1;
        chk("wr_en1", 64'(bus.mem_en), 64'h1);
        chk("wr_we1", 64'(bus.mem_we), 64'h0F);
        chk("wr_addr1", 64'(bus.mem_addr), 64'h021);
        chk("wr_data1", bus.mem_wdata, w1);
        @(negedge clk);
        bus.wvalid = 2'b00;
        #1;
        chk("wr_done_wready", 64'(bus.wready), 64'h0);
        chk("wr_done_en", 64'(bus.mem_en), 64'h0);

        // Readback of the partially written words
        e0 = pat(11'h020);
        e0[31:0] = w0[31:0];
        e1 = pat(11'h021);
        e1[31:0] = w1[31:0];
        bus.req_valid = 2'b01;
        bus.req_we[0] = 1'b0;
        #1;
        chk("rb_ready", 64'(bus.req_ready), 64'h1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        #1;
        chk("rb_rdata0", bus.rdata, e0);
        @(negedge clk);
        #1;
        chk("rb_rdata1", bus.rdata, e1);
        chk("rb_rlast", 64'(bus.rlast), 64'h1);

        // Response routing while the grant has moved to requester 1
        @(negedge clk);
        bus.req_valid   = 2'b01;
        bus.req_addr[0] = 11'h040;
        bus.req_len[0]  = 4'd0;
        bus.req_addr[1] = 11'h050;
        bus.req_len[1]  = 4'd0;
        #1;
        chk("rt_ready0", 64'(bus.req_ready), 64'h1);
        @(negedge clk);
        bus.req_valid = 2'b10;
        #1;
        chk("rt_busy_ready", 64'(bus.req_ready), 64'h0);
        chk("rt_addr0", 64'(bus.mem_addr), 64'h040);
        chk("rt_rvalid_lat", 64'(bus.rvalid), 64'h0);
        @(negedge clk);
        #1;
        chk("rt_ready1", 64'(bus.req_ready), 64'h2);
        chk("rt_rvalid0", 64'(bus.rvalid), 64'h1);
        chk("rt_rlast0", 64'(bus.rlast), 64'h1);
        chk("rt_rdata0", bus.rdata, pat(11'h040));
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        chk("rt_rvalid_gap", 64'(bus.rvalid), 64'h0);
        chk("rt_addr1", 64'(bus.mem_addr), 64'h050);
        @(negedge clk);
        #1;
        chk("rt_rvalid1", 64'(bus.rvalid), 64'h2);
        chk("rt_rdata1", bus.rdata, pat(11'h050));

        // Reset asserted during a 16-beat read after beat 5
        @(negedge clk);
        bus.req_valid   = 2'b10;
        bus.req_addr[1] = 11'h300;
        bus.req_len[1]  = 4'd15;
        #1;
        chk("mr_ready", 64'(bus.req_ready), 64'h2);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.req_valid = 2'b00;
            #1;
            a = 11'h300 + 11'(i);
            chk("mr_addr", 64'(bus.mem_addr), 64'(a));
        end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_rst_outputs("midrst");
        @(negedge clk);
        bus.req_valid   = 2'b01;
        bus.req_addr[0] = 11'h010;
        bus.req_len[0]  = 4'd0;
        #1;
        chk("mr_hold_en", 64'(bus.mem_en), 64'h0);
        chk("mr_hold_rvalid", 64'(bus.rvalid), 64'h0);
        chk("mr_hold_ready", 64'(bus.req_ready), 64'h0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("mr_rel_ready", 64'(bus.req_ready), 64'h0);
        chk("mr_rel_en", 64'(bus.mem_en), 64'h0);
        chk("mr_rel_rvalid", 64'(bus.rvalid), 64'h0);
        @(negedge clk);
        #1;
        chk("mr_idle_ready", 64'(bus.req_ready), 64'h1);
        chk("mr_idle_rvalid", 64'(bus.rvalid), 64'h0);
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        chk("mr_new_en", 64'(bus.mem_en), 64'h1);
        chk("mr_new_addr", 64'(bus.mem_addr), 64'h010);
        @(negedge clk);
        #1;
        chk("mr_new_rvalid", 64'(bus.rvalid), 64'h1);
        chk("mr_new_rdata", bus.rdata, pat(11'h010));
        chk("mr_new_rlast", 64'(bus.rlast), 64'h1);
        @(negedge clk);
        #1;
        chk("mr_new_done", 64'(bus.rvalid), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
